// File: rtl/pa_sysmap_cfg_if.sv
// pa_sysmap_cfg_if
//   TCIP sysmap select-window bus between the TCIP bus interface and the
//   sysmap attribute register file.
//   Signals:
//     tcipif_sysmap_sel    access strobe, one cycle per access
//     tcipif_sysmap_addr   byte offset within the sysmap window
//     tcipif_sysmap_write  1=write, 0=read (qualified by sel)
//     tcipif_sysmap_wdata  write data (qualified by sel & write)
//     sysmap_tcipif_cmplt  access complete, one cycle after sel
//     sysmap_tcipif_rdata  read data, valid only while cmplt
//   Modports: master = TCIP bus interface side, slave = sysmap side.
interface pa_sysmap_cfg_if;
    logic        tcipif_sysmap_sel;
    logic [15:0] tcipif_sysmap_addr;
    logic        tcipif_sysmap_write;
    logic [31:0] tcipif_sysmap_wdata;
    logic        sysmap_tcipif_cmplt;
    logic [31:0] sysmap_tcipif_rdata;

    modport master (
        output tcipif_sysmap_sel,
        output tcipif_sysmap_addr,
        output tcipif_sysmap_write,
        output tcipif_sysmap_wdata,
        input  sysmap_tcipif_cmplt,
        input  sysmap_tcipif_rdata
    );

    modport slave (
        input  tcipif_sysmap_sel,
        input  tcipif_sysmap_addr,
        input  tcipif_sysmap_write,
        input  tcipif_sysmap_wdata,
        output sysmap_tcipif_cmplt,
        output sysmap_tcipif_rdata
    );
endinterface

// File: rtl/pa_sysmap_cfg.sv
// pa_sysmap_cfg
//   System memory-map attribute register file. Holds ENTRY_NUM region upper
//   bounds (ADDR_i, 4 KiB granule) each with a 3-bit attribute (FLG_i), and
//   returns the attribute of the lowest-index region whose bound lies above
//   the lookup address, for both the instruction and the data side.
//   Register map (word access, addr[1:0] ignored, addr[15:8] must be 0):
//     0x8*i+0x0  ADDR_i  bits [31:12] rw
//     0x8*i+0x4  FLG_i   bits [2:0]   rw
//     0xFC       LOCK    bit0, set-only (only with SYSMAP_LOCK_EN)
//   Build option: define SYSMAP_LOCK_EN to add the LOCK register, which
//   blocks all further register writes until reset.
//   Ports:
//     forever_cpuclk   core clock
//     cpurst_b         asynchronous reset, active low
//     tcip             sysmap select-window bus (slave modport)
//     ifu_sysmap_pa    instruction-side lookup address
//     sysmap_ifu_attr  {so, cacheable, bufferable} for ifu_sysmap_pa
//     lsu_sysmap_pa    data-side lookup address
//     sysmap_lsu_attr  {so, cacheable, bufferable} for lsu_sysmap_pa
module pa_sysmap_cfg #(
    parameter int unsigned ENTRY_NUM    = 8,
    parameter logic [2:0]  DEFAULT_ATTR = 3'b100
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    pa_sysmap_cfg_if.slave         tcip,
    input  logic [31:0]            ifu_sysmap_pa,
    output logic [2:0]             sysmap_ifu_attr,
    input  logic [31:0]            lsu_sysmap_pa,
    output logic [2:0]             sysmap_lsu_attr
);

    logic        sel;
    logic        wr;
    logic [15:0] acc_addr;
    logic [31:0] wdata;

    assign sel      = tcip.tcipif_sysmap_sel;
    assign wr       = tcip.tcipif_sysmap_write;
    assign acc_addr = tcip.tcipif_sysmap_addr;
    assign wdata    = tcip.tcipif_sysmap_wdata;

    logic       page_hit;
    logic [4:0] acc_idx;
    logic       acc_flg;
    logic       lock;
    logic       wr_en;

    assign page_hit = (acc_addr[15:8] == 8'h00);
    assign acc_idx  = acc_addr[7:3];
    assign acc_flg  = acc_addr[2];
    assign wr_en    = sel & wr & page_hit & ~lock;

    logic [19:0] addr_q [ENTRY_NUM];
    logic [19:0] addr_d [ENTRY_NUM];
    logic [2:0]  flg_q  [ENTRY_NUM];
    logic [2:0]  flg_d  [ENTRY_NUM];
    logic        cmplt_q, cmplt_d;
    logic [31:0] rdata_q, rdata_d;

`ifdef SYSMAP_LOCK_EN
    logic lock_hit;
    logic lock_q, lock_d;

    assign lock_hit = page_hit & (acc_addr[7:2] == 6'h3F);
    assign lock     = lock_q;
    // wr_en already excludes the locked state, so LOCK can only go 0->1
    assign lock_d   = lock_q | (wr_en & lock_hit & wdata[0]);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign lock = 1'b0;
`endif

    // Register write decode
    always_comb begin
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            addr_d[i] = addr_q[i];
            flg_d[i]  = flg_q[i];
            if (wr_en && (acc_idx == 5'(i))) begin
                if (acc_flg) begin
                    flg_d[i] = wdata[2:0];
                end else begin
                    addr_d[i] = wdata[31:12];
                end
            end
        end
    end

    // Read mux uses pre-write register values, so a same-edge write is not seen
    always_comb begin
        rdata_d = '0;
        if (sel && !wr && page_hit) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                if (acc_idx == 5'(i)) begin
                    rdata_d = acc_flg ? {29'd0, flg_q[i]} : {addr_q[i], 12'd0};
                end
            end
`ifdef SYSMAP_LOCK_EN
            if (lock_hit) begin
                rdata_d = {31'd0, lock_q};
            end
`endif
        end
    end

    assign cmplt_d = sel;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                addr_q[i] <= (i == ENTRY_NUM - 1) ? 20'hFFFFF : '0;
                flg_q[i]  <= 3'b100;
            end
            cmplt_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                addr_q[i] <= addr_d[i];
                flg_q[i]  <= flg_d[i];
            end
            cmplt_q <= cmplt_d;
            rdata_q <= rdata_d;
        end
    end

    assign tcip.sysmap_tcipif_cmplt = cmplt_q;
    assign tcip.sysmap_tcipif_rdata = cmplt_q ? rdata_q : '0;

    // Scan from the top entry down so the lowest matching index wins.
    // An ADDR_i of 0 can never satisfy pn < 0, so it never matches.
    function automatic logic [2:0] lookup(input logic [19:0] pn);
        logic [2:0] attr;
        attr = DEFAULT_ATTR;
        for (int unsigned i = ENTRY_NUM; i > 0; i--) begin
            if (pn < addr_q[i-1]) begin
                attr = flg_q[i-1];
            end
        end
        return attr;
    endfunction

    always_comb begin
        sysmap_ifu_attr = lookup(ifu_sysmap_pa[31:12]);
        sysmap_lsu_attr = lookup(lsu_sysmap_pa[31:12]);
    end

    logic unused_bits;
    assign unused_bits = ^{acc_addr[1:0], wdata[11:3], ifu_sysmap_pa[11:0], lsu_sysmap_pa[11:0]};

endmodule

// File: tb/tb_pa_sysmap_cfg.sv
// tb_pa_sysmap_cfg
//   Directed testbench for pa_sysmap_cfg. Inputs are driven on the falling
//   edge and outputs sampled on the falling edge, away from the rising edge.
//   Honours SYSMAP_LOCK_EN when the same macro is defined for the build.
module tb_pa_sysmap_cfg;

    logic        clk;
    logic        rst_b;
    logic [31:0] ifu_pa;
    logic [31:0] lsu_pa;
    logic [2:0]  ifu_attr;
    logic [2:0]  lsu_attr;
    int unsigned n_checks;
    int unsigned n_fail;

    pa_sysmap_cfg_if bus ();

    pa_sysmap_cfg #(
        .ENTRY_NUM    (8),
        .DEFAULT_ATTR (3'b100)
    ) dut (
        .forever_cpuclk  (clk),
        .cpurst_b        (rst_b),
        .tcip            (bus.slave),
        .ifu_sysmap_pa   (ifu_pa),
        .sysmap_ifu_attr (ifu_attr),
        .lsu_sysmap_pa   (lsu_pa),
        .sysmap_lsu_attr (lsu_attr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Caller is at a falling edge. Drives one access, checks the completion
    // pulse and its clearing, returns the read data seen with cmplt.
    task automatic acc(input string tag, input logic w, input logic [15:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        bus.tcipif_sysmap_sel   = 1'b1;
        bus.tcipif_sysmap_write = w;
        bus.tcipif_sysmap_addr  = a;
        bus.tcipif_sysmap_wdata = d;
        @(negedge clk);
        chk({tag, "_cmplt"}, {31'd0, bus.sysmap_tcipif_cmplt}, 32'd1);
        rd = bus.sysmap_tcipif_rdata;
        if (w) chk({tag, "_wr_rdata"}, bus.sysmap_tcipif_rdata, 32'd0);
        bus.tcipif_sysmap_sel   = 1'b0;
        bus.tcipif_sysmap_write = 1'b0;
        @(negedge clk);
        chk({tag, "_cmplt_off"}, {31'd0, bus.sysmap_tcipif_cmplt}, 32'd0);
        chk({tag, "_rdata_off"}, bus.sysmap_tcipif_rdata, 32'd0);
    endtask

    task automatic wr(input string tag, input logic [15:0] a, input logic [31:0] d);
        logic [31:0] rd;
        acc(tag, 1'b1, a, d, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        acc(tag, 1'b0, a, 32'd0, rd);
        chk({tag, "_rdata"}, rd, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_b    = 1'b0;
        bus.tcipif_sysmap_sel   = 1'b0;
        bus.tcipif_sysmap_write = 1'b0;
        bus.tcipif_sysmap_addr  = 16'h0;
        bus.tcipif_sysmap_wdata = 32'h0;
        ifu_pa = 32'h2000_0000;
        lsu_pa = 32'h2000_0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ifu_attr", {29'd0, ifu_attr}, 32'h4);
        chk("rst_lsu_attr", {29'd0, lsu_attr}, 32'h4);
        chk("rst_cmplt", {31'd0, bus.sysmap_tcipif_cmplt}, 32'd0);
        chk("rst_rdata", bus.sysmap_tcipif_rdata, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        lsu_pa = 32'hFFFF_F800;
        #1 chk("above_top_default", {29'd0, lsu_attr}, 32'h4);
        rd_chk("rst_addr7", 16'h0038, 32'hFFFF_F000);
        rd_chk("rst_flg3", 16'h001C, 32'h4);

        // Program entry 0
        wr("wr_addr0", 16'h0000, 32'h1000_0000);
        wr("wr_flg0", 16'h0004, 32'h0000_0003);
        lsu_pa = 32'h0FFF_FFFC;
        #1 chk("lu_below_b0", {29'd0, lsu_attr}, 32'h3);
        lsu_pa = 32'h1000_0000;
        #1 chk("lu_at_b0", {29'd0, lsu_attr}, 32'h4);

        // Back-to-back write then read of ADDR_1
        bus.tcipif_sysmap_sel   = 1'b1;
        bus.tcipif_sysmap_write = 1'b1;
        bus.tcipif_sysmap_addr  = 16'h0008;
        bus.tcipif_sysmap_wdata = 32'h2000_0000;
        @(negedge clk);
        chk("b2b_cmplt1", {31'd0, bus.sysmap_tcipif_cmplt}, 32'd1);
        chk("b2b_rdata1", bus.sysmap_tcipif_rdata, 32'd0);
        bus.tcipif_sysmap_write = 1'b0;
        bus.tcipif_sysmap_wdata = 32'h0;
        @(negedge clk);
        chk("b2b_cmplt2", {31'd0, bus.sysmap_tcipif_cmplt}, 32'd1);
        chk("b2b_rdata2", bus.sysmap_tcipif_rdata, 32'h2000_0000);
        bus.tcipif_sysmap_sel = 1'b0;
        @(negedge clk);
        chk("b2b_cmplt3", {31'd0, bus.sysmap_tcipif_cmplt}, 32'd0);
        chk("b2b_rdata3", bus.sysmap_tcipif_rdata, 32'd0);

        // Same-cycle write vs lookup of entry 0
        ifu_pa = 32'h0000_1000;
        bus.tcipif_sysmap_sel   = 1'b1;
        bus.tcipif_sysmap_write = 1'b1;
        bus.tcipif_sysmap_addr  = 16'h0004;
        bus.tcipif_sysmap_wdata = 32'h0000_0002;
        #1 chk("same_cyc_old", {29'd0, ifu_attr}, 32'h3);
        @(negedge clk);
        bus.tcipif_sysmap_sel   = 1'b0;
        bus.tcipif_sysmap_write = 1'b0;
        chk("same_cyc_new", {29'd0, ifu_attr}, 32'h2);
        @(negedge clk);

        // Field masking on readback
        wr("wr_addr2", 16'h0010, 32'h3000_0ABC);
        rd_chk("rd_addr2_mask", 16'h0010, 32'h3000_0000);
        wr("wr_flg2", 16'h0014, 32'hFFFF_FFF9);
        rd_chk("rd_flg2_mask", 16'h0014, 32'h0000_0001);

        // Non-ascending bound: entry 2 still wins over entry 3
        wr("wr_addr3", 16'h0018, 32'hF000_0000);
        wr("wr_flg3", 16'h001C, 32'h0000_0006);
        lsu_pa = 32'h2800_0000;
        ifu_pa = 32'h3800_0000;
        #1 chk("prio_lsu", {29'd0, lsu_attr}, 32'h1);
        chk("prio_ifu", {29'd0, ifu_attr}, 32'h6);

        // Unmapped offsets
        rd_chk("rd_0x40", 16'h0040, 32'd0);
        rd_chk("rd_0x1000", 16'h1000, 32'd0);
        wr("wr_0x40", 16'h0040, 32'hFFFF_FFFF);
        wr("wr_0x1000", 16'h1000, 32'hFFFF_FFFF);
        wr("wr_0x1004", 16'h1004, 32'hFFFF_FFFF);
        rd_chk("addr0_kept", 16'h0000, 32'h1000_0000);
        rd_chk("flg0_kept", 16'h0004, 32'h2);

`ifdef SYSMAP_LOCK_EN
        rd_chk("lock_rst", 16'h00FC, 32'd0);
        wr("wr_lock", 16'h00FC, 32'h1);
        rd_chk("lock_set", 16'h00FC, 32'd1);
        wr("wr_flg0_locked", 16'h0004, 32'h1);
        rd_chk("flg0_locked", 16'h0004, 32'h2);
`else
        wr("wr_0xfc", 16'h00FC, 32'h1);
        rd_chk("rd_0xfc", 16'h00FC, 32'd0);
        wr("wr_flg0_open", 16'h0004, 32'h5);
        rd_chk("flg0_open", 16'h0004, 32'h5);
`endif

        // Reset during the completion cycle of a read
        bus.tcipif_sysmap_sel   = 1'b1;
        bus.tcipif_sysmap_addr  = 16'h0000;
        @(posedge clk);
        #1 rst_b = 1'b0;
        bus.tcipif_sysmap_sel = 1'b0;
        @(negedge clk);
        chk("rstmid_cmplt", {31'd0, bus.sysmap_tcipif_cmplt}, 32'd0);
        chk("rstmid_rdata", bus.sysmap_tcipif_rdata, 32'd0);
        lsu_pa = 32'h0000_1000;
        ifu_pa = 32'h2800_0000;
        #1 chk("rstmid_lsu", {29'd0, lsu_attr}, 32'h4);
        chk("rstmid_ifu", {29'd0, ifu_attr}, 32'h4);
        @(negedge clk);
        chk("rstmid_cmplt2", {31'd0, bus.sysmap_tcipif_cmplt}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        rd_chk("rstmid_addr0", 16'h0000, 32'd0);
        rd_chk("rstmid_flg0", 16'h0004, 32'h4);
        rd_chk("rstmid_addr7", 16'h0038, 32'hFFFF_F000);
`ifdef SYSMAP_LOCK_EN
        rd_chk("rstmid_lock", 16'h00FC, 32'd0);
`endif
        wr("post_rst_flg0", 16'h0004, 32'h1);
        rd_chk("post_rst_flg0", 16'h0004, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
